// File: rtl/text_terminal_writer.sv
// Text terminal front end: byte stream in, single-cycle cell writes out.
// Tracks a cursor over a COLUMNS x ROWS grid and handles CR/LF/BS/FF.
module text_terminal_writer #(
  parameter int COLUMNS       = 12,
  parameter int ROWS          = 2,
  parameter int FONT_NUM_CHAR = 256,
  parameter int BLANK_CHAR    = 8'h20,
  localparam int CW = $clog2(FONT_NUM_CHAR),
  localparam int XW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1,
  localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_rx_dv,
  input  logic [CW-1:0] i_rx_byte,
  output logic          o_rx_ready,
  output logic          o_wr_en,
  output logic [CW-1:0] o_wr_character,
  output logic [XW-1:0] o_wr_x_pos,
  output logic [YW-1:0] o_wr_y_pos,
  output logic [XW-1:0] o_cursor_x,
  output logic [YW-1:0] o_cursor_y,
  output logic          o_busy
);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_WRITE
  } state_t;

  localparam logic [XW-1:0] XMAX  = XW'(COLUMNS - 1);
  localparam logic [YW-1:0] YMAX  = YW'(ROWS - 1);
  localparam logic [CW-1:0] BLANK = CW'(BLANK_CHAR);

  state_t        r_state;
  state_t        w_next;
  logic          r_wr_en;
  logic [CW-1:0] r_wr_chr;
  logic [XW-1:0] r_wr_x;
  logic [YW-1:0] r_wr_y;
  logic [XW-1:0] r_cur_x;
  logic [YW-1:0] r_cur_y;
  logic [XW-1:0] r_clr_x;
  logic [YW-1:0] r_clr_y;
  logic          r_busy;
  logic          r_rx_ready;

  logic          w_wr_en_d;
  logic [CW-1:0] w_chr_d;
  logic [XW-1:0] w_x_d;
  logic [YW-1:0] w_y_d;
  logic [XW-1:0] w_cx_d;
  logic [YW-1:0] w_cy_d;
  logic [XW-1:0] w_kx_d;
  logic [YW-1:0] w_ky_d;

  logic          w_accept;
  logic          w_is_cr;
  logic          w_is_lf;
  logic          w_is_bs;
  logic          w_is_ff;
  logic          w_clr_last;
  logic [YW-1:0] w_y_inc;

  assign w_accept   = i_rx_dv && r_rx_ready;
  assign w_is_cr    = (i_rx_byte == CW'(8'h0D));
  assign w_is_lf    = (i_rx_byte == CW'(8'h0A));
  assign w_is_bs    = (i_rx_byte == CW'(8'h08));
  assign w_is_ff    = (i_rx_byte == CW'(8'h0C));
  assign w_clr_last = (r_clr_x == XMAX) && (r_clr_y == YMAX);
  assign w_y_inc    = (r_cur_y == YMAX) ? '0 : r_cur_y + YW'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_CLEAR;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_CLEAR: if (w_clr_last) w_next = S_IDLE;
      S_IDLE: begin
        if (w_accept) begin
          unique case (1'b1)
            w_is_cr: w_next = S_IDLE;
            w_is_lf: w_next = S_IDLE;
            w_is_bs: w_next = (r_cur_x != '0) ? S_WRITE : S_IDLE;
            w_is_ff: w_next = S_CLEAR;
            default: w_next = S_WRITE;
          endcase
        end
      end
      S_WRITE: w_next = S_IDLE;
      default: w_next = S_CLEAR;
    endcase
  end

  // Strobes are registered on the transition, so WRITE is the strobe cycle.
  always_comb begin
    w_wr_en_d = 1'b0;
    w_chr_d   = r_wr_chr;
    w_x_d     = r_wr_x;
    w_y_d     = r_wr_y;
    w_cx_d    = r_cur_x;
    w_cy_d    = r_cur_y;
    w_kx_d    = r_clr_x;
    w_ky_d    = r_clr_y;
    unique case (r_state)
      S_CLEAR: begin
        w_wr_en_d = 1'b1;
        w_chr_d   = BLANK;
        w_x_d     = r_clr_x;
        w_y_d     = r_clr_y;
        if (w_clr_last) begin
          w_kx_d = '0;
          w_ky_d = '0;
          w_cx_d = '0;
          w_cy_d = '0;
        end else if (r_clr_x == XMAX) begin
          w_kx_d = '0;
          w_ky_d = r_clr_y + YW'(1);
        end else begin
          w_kx_d = r_clr_x + XW'(1);
        end
      end
      S_IDLE: begin
        if (w_accept) begin
          unique case (1'b1)
            w_is_cr: w_cx_d = '0;
            w_is_lf: w_cy_d = w_y_inc;
            w_is_bs: begin
              if (r_cur_x != '0) begin
                w_cx_d    = r_cur_x - XW'(1);
                w_wr_en_d = 1'b1;
                w_chr_d   = BLANK;
                w_x_d     = r_cur_x - XW'(1);
                w_y_d     = r_cur_y;
              end
            end
            w_is_ff: begin
              w_kx_d = '0;
              w_ky_d = '0;
            end
            default: begin
              w_wr_en_d = 1'b1;
              w_chr_d   = i_rx_byte;
              w_x_d     = r_cur_x;
              w_y_d     = r_cur_y;
              if (r_cur_x == XMAX) begin
                w_cx_d = '0;
                w_cy_d = w_y_inc;
              end else begin
                w_cx_d = r_cur_x + XW'(1);
              end
            end
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_en    <= 1'b0;
      r_wr_chr   <= '0;
      r_wr_x     <= '0;
      r_wr_y     <= '0;
      r_cur_x    <= '0;
      r_cur_y    <= '0;
      r_clr_x    <= '0;
      r_clr_y    <= '0;
      r_busy     <= 1'b1;
      r_rx_ready <= 1'b0;
    end else begin
      r_wr_en    <= w_wr_en_d;
      r_wr_chr   <= w_chr_d;
      r_wr_x     <= w_x_d;
      r_wr_y     <= w_y_d;
      r_cur_x    <= w_cx_d;
      r_cur_y    <= w_cy_d;
      r_clr_x    <= w_kx_d;
      r_clr_y    <= w_ky_d;
      r_busy     <= (w_next == S_CLEAR);
      r_rx_ready <= (w_next == S_IDLE);
    end
  end

  assign o_rx_ready     = r_rx_ready;
  assign o_wr_en        = r_wr_en;
  assign o_wr_character = r_wr_chr;
  assign o_wr_x_pos     = r_wr_x;
  assign o_wr_y_pos     = r_wr_y;
  assign o_cursor_x     = r_cur_x;
  assign o_cursor_y     = r_cur_y;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_text_terminal_writer.sv
// Directed bench for text_terminal_writer with a write scoreboard.
// Cursor model and expected cell writes are derived from the byte stream.
module tb_text_terminal_writer;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_rx_dv;
  logic [7:0] i_rx_byte;
  logic       o_rx_ready;
  logic       o_wr_en;
  logic [7:0] o_wr_character;
  logic [3:0] o_wr_x_pos;
  logic [0:0] o_wr_y_pos;
  logic [3:0] o_cursor_x;
  logic [0:0] o_cursor_y;
  logic       o_busy;

  typedef struct {
    int c;
    int x;
    int y;
  } wr_t;

  wr_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  int  mx = 0;
  int  my = 0;

  text_terminal_writer dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_rx_dv        (i_rx_dv),
    .i_rx_byte      (i_rx_byte),
    .o_rx_ready     (o_rx_ready),
    .o_wr_en        (o_wr_en),
    .o_wr_character (o_wr_character),
    .o_wr_x_pos     (o_wr_x_pos),
    .o_wr_y_pos     (o_wr_y_pos),
    .o_cursor_x     (o_cursor_x),
    .o_cursor_y     (o_cursor_y),
    .o_busy         (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (o_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr", 1, 0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_char", 32'(o_wr_character), e.c);
        check("wr_x", 32'(o_wr_x_pos), e.x);
        check("wr_y", 32'(o_wr_y_pos), e.y);
      end
    end
  end

  task automatic push_clear(input int n);
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.c = 8'h20;
      e.x = i % 12;
      e.y = i / 12;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_clear_done();
    int k;
    k = 0;
    while (o_busy !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("clear_timeout", 32'(k < 100), 1);
    check("ready_after_clear", 32'(o_rx_ready), 1);
    @(negedge clk);
    check("clear_q_empty", exp_q.size(), 0);
    mx = 0;
    my = 0;
    check("cur_x_home", 32'(o_cursor_x), 0);
    check("cur_y_home", 32'(o_cursor_y), 0);
  endtask

  // Returns at the negedge of the cycle following acceptance.
  task automatic send(input logic [7:0] b);
    int k;
    wr_t e;
    k = 0;
    while (o_rx_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("ready_timeout", 32'(k < 50), 1);
    unique case (b)
      8'h0D: mx = 0;
      8'h0A: my = (my + 1) % 2;
      8'h08: begin
        if (mx > 0) begin
          mx--;
          e.c = 8'h20;
          e.x = mx;
          e.y = my;
          exp_q.push_back(e);
        end
      end
      8'h0C: ;
      default: begin
        e.c = b;
        e.x = mx;
        e.y = my;
        exp_q.push_back(e);
        if (mx == 11) begin
          mx = 0;
          my = (my + 1) % 2;
        end else begin
          mx++;
        end
      end
    endcase
    i_rx_dv   = 1'b1;
    i_rx_byte = b;
    @(posedge clk);
    #1 i_rx_dv = 1'b0;
    @(negedge clk);
    if (b != 8'h0C) begin
      check("cursor_x", 32'(o_cursor_x), mx);
      check("cursor_y", 32'(o_cursor_y), my);
    end
  endtask

  initial begin
    int k;
    i_rst     = 1'b1;
    i_rx_dv   = 1'b0;
    i_rx_byte = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en", 32'(o_wr_en), 0);
    check("rst_busy", 32'(o_busy), 1);
    check("rst_ready", 32'(o_rx_ready), 0);
    check("rst_wr_x", 32'(o_wr_x_pos), 0);
    check("rst_wr_y", 32'(o_wr_y_pos), 0);
    check("rst_wr_chr", 32'(o_wr_character), 0);
    check("rst_cur_x", 32'(o_cursor_x), 0);
    push_clear(24);
    i_rst = 1'b0;
    wait_clear_done();

    send(8'h41);
    check("glyph_wr_en", 32'(o_wr_en), 1);
    check("glyph_ready_low", 32'(o_rx_ready), 0);
    check("glyph_cur_x1", 32'(o_cursor_x), 1);
    @(negedge clk);
    check("glyph_ready_back", 32'(o_rx_ready), 1);
    check("glyph_one_strobe", 32'(o_wr_en), 0);

    send(8'h0D);
    for (int i = 0; i < 13; i++) send(8'h42);
    check("wrap_cur_x", 32'(o_cursor_x), 1);
    check("wrap_cur_y", 32'(o_cursor_y), 1);
    for (int i = 0; i < 10; i++) send(8'h43);
    send(8'h44);
    check("corner_cur_x", 32'(o_cursor_x), 0);
    check("corner_cur_y", 32'(o_cursor_y), 0);

    send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h45);
    send(8'h0D);
    check("cr_no_wr", 32'(o_wr_en), 0);
    check("cr_cur_x", 32'(o_cursor_x), 0);
    send(8'h0A);
    check("lf_no_wr", 32'(o_wr_en), 0);
    check("lf_cur_y", 32'(o_cursor_y), 0);
    send(8'h08);
    check("bs0_no_wr", 32'(o_wr_en), 0);
    check("bs0_cur_x", 32'(o_cursor_x), 0);

    for (int i = 0; i < 3; i++) send(8'h46);
    send(8'h08);
    check("bs_wr_en", 32'(o_wr_en), 1);
    check("bs_wr_chr", 32'(o_wr_character), 8'h20);
    check("bs_cur_x", 32'(o_cursor_x), 2);

    send(8'h0C);
    check("ff_busy", 32'(o_busy), 1);
    check("ff_ready", 32'(o_rx_ready), 0);
    push_clear(10);
    i_rx_dv   = 1'b1;
    i_rx_byte = 8'h47;
    k = 0;
    for (int c = 0; c < 100; c++) begin
      if (o_wr_en === 1'b1) k++;
      if (k == 10) break;
      check("clr_ready_low", 32'(o_rx_ready), 0);
      @(negedge clk);
    end
    check("ff_clear_count", k, 10);
    i_rst = 1'b1;
    push_clear(24);
    @(posedge clk);
    #1;
    i_rst   = 1'b0;
    i_rx_dv = 1'b0;
    @(negedge clk);
    check("midrst_wr_en", 32'(o_wr_en), 0);
    check("midrst_busy", 32'(o_busy), 1);
    check("midrst_ready", 32'(o_rx_ready), 0);
    wait_clear_done();
    repeat (3) @(negedge clk);
    check("final_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
